// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: adds two WORDS*N-bit operands by streaming N-bit chunks,
// LSB chunk first, through an external combinational fast_adder, one chunk per
// clock. The inter-chunk carry is registered. valid/ready on both sides.
module wide_add_sequencer #(
   parameter int N     = 10,
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N*WORDS-1:0]   a,
   input  logic [N*WORDS-1:0]   b,
   input  logic                 cin,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N*WORDS-1:0]   sum,
   output logic                 cout,
   output logic [N-1:0]         add_inp1,
   output logic [N-1:0]         add_inp2,
   output logic                 add_cin,
   input  logic [N-1:0]         add_result,
   input  logic                 add_cout
);

   localparam int W    = N * WORDS;
   localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDXW-1:0] IDX_ZERO = IDXW'(0);
   localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [W-1:0]      r_a;
   logic [W-1:0]      r_b;
   logic              r_carry;
   logic [IDXW-1:0]   r_idx;
   logic [N-1:0]      r_sum_words [WORDS];
   logic              r_cout;
   logic              r_in_ready;
   logic              r_out_valid;

   logic [N-1:0]      w_a_words [WORDS];
   logic [N-1:0]      w_b_words [WORDS];
   logic              w_accept;
   logic              w_last;
   logic [N-1:0]      w_add_inp1;
   logic [N-1:0]      w_add_inp2;
   logic              w_add_cin;

   // Chunk views of the latched operands and flat view of the sum chunks.
   genvar g;
   generate
      for (g = 0; g < WORDS; g++) begin : g_words
         assign w_a_words[g]      = r_a[g*N +: N];
         assign w_b_words[g]      = r_b[g*N +: N];
         assign sum[g*N +: N]     = r_sum_words[g];
      end
   endgenerate

   assign w_accept  = in_valid & r_in_ready;
   assign w_last    = (r_idx == IDX_LAST);
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign cout      = r_cout;
   assign add_inp1  = w_add_inp1;
   assign add_inp2  = w_add_inp2;
   assign add_cin   = w_add_cin;

   // Next-state decode for the IDLE -> RUN -> DONE sequence.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next_state = S_RUN;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_next_state = S_DONE;
            end else begin
               w_next_state = S_RUN;
            end
         end
         S_DONE: begin
            if (r_out_valid && out_ready) begin
               w_next_state = S_IDLE;
            end else begin
               w_next_state = S_DONE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Drive the adder with the current chunk during RUN, zero otherwise.
   always_comb begin
      w_add_inp1 = {N{1'b0}};
      w_add_inp2 = {N{1'b0}};
      w_add_cin  = 1'b0;
      if (r_state == S_RUN) begin
         w_add_inp1 = w_a_words[r_idx];
         w_add_inp2 = w_b_words[r_idx];
         w_add_cin  = r_carry;
      end else begin
         w_add_inp1 = {N{1'b0}};
         w_add_inp2 = {N{1'b0}};
         w_add_cin  = 1'b0;
      end
   end

   // State, handshake flags, operand latch and per-chunk result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_a         <= {W{1'b0}};
         r_b         <= {W{1'b0}};
         r_carry     <= 1'b0;
         r_idx       <= IDX_ZERO;
         r_cout      <= 1'b0;
         for (int k = 0; k < WORDS; k++) begin
            r_sum_words[k] <= {N{1'b0}};
         end
      end else begin
         r_state     <= w_next_state;
         // Handshake flags follow the state being entered so they are
         // high exactly while in IDLE / DONE.
         r_in_ready  <= (w_next_state == S_IDLE);
         r_out_valid <= (w_next_state == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= cin;
                  r_idx   <= IDX_ZERO;
               end else begin
                  r_idx   <= IDX_ZERO;
               end
            end
            S_RUN: begin
               r_sum_words[r_idx] <= add_result;
               r_carry            <= add_cout;
               if (w_last) begin
                  r_cout <= add_cout;
                  r_idx  <= IDX_ZERO;
               end else begin
                  r_idx  <= r_idx + IDX_ONE;
               end
            end
            S_DONE: begin
               r_idx <= IDX_ZERO;
            end
            default: begin
               r_idx <= IDX_ZERO;
            end
         endcase
      end
   end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
Sequential front-end that adds two WORDS*N-bit operands by streaming N-bit chunks, LSB chunk first, through the combinational fast_adder stage, one chunk per clock. The carry is registered between chunks. Operands arrive and results leave over valid/ready handshakes. It sits directly upstream of the N-bit fast_adder, driving its Inp1/Inp2/Cin and consuming its Result/Cout.

Parameters:
N, 10, chunk width; must match the N of the attached fast_adder
WORDS, 4, chunks per operand (>=1); total operand width W = N*WORDS

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
a  input  W  operand A
b  input  W  operand B
cin  input  1  carry-in to chunk 0
out_valid  output  1  sum/cout valid
out_ready  input  1  consumer accepts result
sum  output  W  registered W-bit sum
cout  output  1  carry out of the top chunk
add_inp1  output  N  to fast_adder Inp1
add_inp2  output  N  to fast_adder Inp2
add_cin  output  1  to fast_adder Cin
add_result  input  N  from fast_adder Result
add_cout  input  1  from fast_adder Cout

Behaviour:
- One clock domain; rst_n is asynchronous and active-low. Assertion at any time, including mid-operation, forces state IDLE immediately. In-flight operands are discarded.
- Reset values: in_ready=0 while rst_n=0 and 1 from the first edge after release (IDLE). out_valid=0, sum=0, cout=0, chunk index=0, carry register=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready at an edge: latch a, b, cin; index<=0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Combinationally: add_inp1=a_reg[idx*N+:N], add_inp2=b_reg[idx*N+:N], add_cin=carry_reg (cin_reg for idx 0).
  - Each edge: sum[idx*N+:N]<=add_result; carry_reg<=add_cout; idx<=idx+1.
  - When idx==WORDS-1: cout<=add_cout; go to DONE. WORDS=1 therefore spends exactly one RUN cycle.
- DONE:
  - out_valid=1, in_ready=0.
  - sum and cout are held stable until out_valid&out_ready at an edge, then go to IDLE.
  - out_ready low holds DONE indefinitely with no change to outputs.
- add_inp1, add_inp2 and add_cin are driven 0 outside RUN.
- Latency: operand acceptance at edge T gives out_valid=1 after edge T+WORDS. With out_ready tied high, throughput is one result per WORDS+2 cycles.
- No simultaneous accept/emit: in_ready is only high in IDLE, so a new operand is never accepted in the DONE→IDLE cycle.
- a, b and cin are sampled only at the accept edge; later input changes have no effect.
- sum bits for chunks not yet processed retain previous values during RUN. They are only meaningful when out_valid=1.
- Arithmetic is modulo 2^W with carry out on cout: {cout,sum} = a + b + cin exactly.
- in_valid may drop without acceptance (no requirement to hold). Per chunk, the result is equivalent to the fast_adder's Result/Cout.

Test Plan:
- N=10, WORDS=4, a=250, b=400, cin=0 → out_valid 4 cycles after accept; sum=650, cout=0; add_cin=0 on every chunk.
- a=250, b=400, cin=1 → sum=651, cout=0.
- a=0x3FF, b=1, cin=0 → chunk0 result 0 with add_cout=1; chunk1 add_cin=1; sum=0x400, cout=0.
- a=2^40-1, b=1, cin=0 → carry ripples through all 4 chunks; sum=0, cout=1. Also a=750, b=300 → sum=1050, cout=0.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, sum/cout stable, in_ready=0. Raise out_ready → one-cycle accept, then in_ready=1.
- Reset mid-RUN: assert rst_n=0 at chunk index 2 → immediately out_valid=0, sum=0, cout=0. After release, a new 100+200 completes with sum=300, with no residue from the aborted operation.
